// File: rtl/decode_pkg.sv
// Shared opcode constants, FSM state encoding and immediate-format helper
// for the decode pipeline.
package decode_pkg;

  localparam int unsigned OP_JMP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_LODI = 5;
  localparam int unsigned OP_LD   = 6;
  localparam int unsigned OP_ST   = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Opcodes that carry a full-width immediate instead of a sign-extended reg field.
  function automatic logic is_long_imm(input logic [31:0] op);
    return (op == OP_JMP) || (op == OP_LODI);
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational split of a raw instruction word into opcode, three
// register indices and an immediate.
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned INST_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned IMM_W  = 8
) (
  input  logic [INST_W-1:0] i_inst,
  output logic [OP_W-1:0]   o_op,
  output logic [REG_W-1:0]  o_reg0,
  output logic [REG_W-1:0]  o_reg1,
  output logic [REG_W-1:0]  o_reg2,
  output logic [IMM_W-1:0]  o_imm,
  output logic              o_long_imm
);

  assign o_op       = i_inst[INST_W-1 -: OP_W];
  assign o_reg0     = i_inst[3*REG_W-1 -: REG_W];
  assign o_reg1     = i_inst[2*REG_W-1 -: REG_W];
  assign o_reg2     = i_inst[REG_W-1:0];
  assign o_long_imm = is_long_imm(32'(o_op));

  always_comb begin
    o_imm = IMM_W'($signed(i_inst[REG_W-1:0]));
    if (o_long_imm) begin
      o_imm = i_inst[IMM_W-1:0];
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Instruction decode stage: decodes at the input and holds up to two decoded
// entries (output register plus skid) so in_ready never depends on out_ready.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned INST_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic [REG_W-1:0]  reg0,
  output logic [REG_W-1:0]  reg1,
  output logic [REG_W-1:0]  reg2,
  output logic [IMM_W-1:0]  imm,
  output logic              long_imm,
  output logic [CNT_W-1:0]  dec_count
);

  localparam int unsigned ENT_W = OP_W + 3 * REG_W + IMM_W + 1;

  if (INST_W != OP_W + 3 * REG_W || IMM_W < REG_W || IMM_W > INST_W - OP_W) begin : g_bad_params
    $error("decode_pipe: inconsistent INST_W/OP_W/REG_W/IMM_W");
  end

  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_reg0, w_reg1, w_reg2;
  logic [IMM_W-1:0] w_imm;
  logic             w_long_imm;
  logic [ENT_W-1:0] w_dec;
  logic             w_in_xfer, w_out_xfer;

  state_e           r_state, w_state_nxt;
  logic [ENT_W-1:0] r_out, w_out_nxt;
  logic [ENT_W-1:0] r_skid, w_skid_nxt;
  logic [CNT_W-1:0] r_count;

  decode_fields #(
    .INST_W(INST_W),
    .OP_W  (OP_W),
    .REG_W (REG_W),
    .IMM_W (IMM_W)
  ) u_fields (
    .i_inst    (inst),
    .o_op      (w_op),
    .o_reg0    (w_reg0),
    .o_reg1    (w_reg1),
    .o_reg2    (w_reg2),
    .o_imm     (w_imm),
    .o_long_imm(w_long_imm)
  );

  assign w_dec      = {w_op, w_reg0, w_reg1, w_reg2, w_imm, w_long_imm};
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_xfer  = in_valid && in_ready && !flush;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_out_nxt   = w_dec;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_out_nxt = w_dec;
          end else if (w_in_xfer) begin
            w_skid_nxt  = w_dec;
            w_state_nxt = ST_TWO;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_out_nxt   = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // A flush cycle counts nothing, even if downstream happened to take the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
      if (w_out_xfer && !flush) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign {op, reg0, reg1, reg2, imm, long_imm} = r_out;
  assign dec_count = r_count;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: queue-based reference model checked every cycle,
// plus hand-computed literal checks of the key scenarios.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, long_imm;
  logic [15:0] inst;
  logic [3:0]  op, reg0, reg1, reg2, dec_count;
  logic [7:0]  imm;

  always #5 clk = ~clk;

  decode_pipe #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op       (op),
    .reg0     (reg0),
    .reg1     (reg1),
    .reg2     (reg2),
    .imm      (imm),
    .long_imm (long_imm),
    .dec_count(dec_count)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] r0;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [7:0] imm;
    logic       lng;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic ent_t ref_decode(input logic [15:0] w);
    ent_t e;
    e.op = w[15:12];
    e.r0 = w[11:8];
    e.r1 = w[7:4];
    e.r2 = w[3:0];
    if (e.op == 4'd0 || e.op == 4'd5) begin
      e.imm = w[7:0];
      e.lng = 1'b1;
    end else begin
      e.imm = {{4{w[3]}}, w[3:0]};
      e.lng = 1'b0;
    end
    return e;
  endfunction

  // Reference: a FIFO of at most two decoded entries and a wrapping count.
  always @(posedge clk) begin : model
    bit in_x, out_x;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      in_x  = in_valid && (mq.size() < 2);
      out_x = (mq.size() > 0) && out_ready;
      if (out_x) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % 16;
      end
      if (in_x) mq.push_back(ref_decode(inst));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("dec_count", {28'd0, dec_count}, mcnt);
      if (mq.size() > 0) chk("fields", {3'd0, op, reg0, reg1, reg2, imm, long_imm}, {3'd0, mq[0]});
    end
  end

  task automatic drive(input logic v, input logic [15:0] w, input logic r, input logic f);
    in_valid  = v;
    inst      = w;
    out_ready = r;
    flush     = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst    = 1'b0;
    cmp_en = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {28'd0, dec_count}, 32'd0);
    chk("rst_fields", {op, reg0, reg1, reg2, imm, long_imm}, 32'd0);

    // LODI: full 8-bit immediate
    drive(1'b1, 16'h5A3C, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("lodi_valid", {31'd0, out_valid}, 32'd1);
    chk("lodi_op", {28'd0, op}, 32'd5);
    chk("lodi_reg0", {28'd0, reg0}, 32'hA);
    chk("lodi_imm", {24'd0, imm}, 32'h3C);
    chk("lodi_long", {31'd0, long_imm}, 32'd1);
    tick();
    chk("lodi_count", {28'd0, dec_count}, 32'd1);

    // Sign-extended short immediates
    drive(1'b1, 16'h2129, 1'b1, 1'b0);
    tick();
    chk("sext_neg_imm", {24'd0, imm}, 32'hF9);
    chk("sext_neg_long", {31'd0, long_imm}, 32'd0);
    drive(1'b1, 16'h2127, 1'b1, 1'b0);
    tick();
    chk("sext_pos_imm", {24'd0, imm}, 32'h07);
    chk("sext_pos_regs", {20'd0, op, reg0, reg1, reg2}, 32'h2127);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("sext_count", {28'd0, dec_count}, 32'd3);

    // Backpressure: third of three back-to-back inputs must stall
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", {28'd0, op}, 32'd1);
    tick();
    chk("bp_hold", {28'd0, op}, 32'd1);
    drive(1'b1, 16'h3333, 1'b1, 1'b0);
    tick();
    chk("bp_second", {28'd0, op}, 32'd2);
    chk("bp_count1", {28'd0, dec_count}, 32'd4);
    tick();
    chk("bp_third", {28'd0, op}, 32'd3);
    chk("bp_count2", {28'd0, dec_count}, 32'd5);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_count3", {28'd0, dec_count}, 32'd6);

    // Flush from full with a simultaneous input
    drive(1'b1, 16'h4444, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h6666, 1'b0, 1'b0);
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h7777, 1'b1, 1'b1);
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_count", {28'd0, dec_count}, 32'd6);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("fl_no_entry", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream
    drive(1'b1, 16'h5A3C, 1'b0, 1'b0);
    tick();
    chk("mr_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_count", {28'd0, dec_count}, 32'd0);
    chk("mr_fields", {op, reg0, reg1, reg2, imm, long_imm}, 32'd0);
    tick();
    chk("mr_discard", {31'd0, out_valid}, 32'd0);

    // Counter wrap with CNT_W=4: 17 transfers -> 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'($urandom), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("wrap_count", {28'd0, dec_count}, 32'd1);
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inst      = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();
    @(posedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
